uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame, legal 5..8.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal 2..255.
REQ-003 Parameter PARITY_MODE, default 1: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: legal 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: power of two, 2..16.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_data  in  DATA_BITS  word to transmit, LSB sent first.
REQ-009 in_valid  in  1  in_data is offered.
REQ-010 in_ready  out  1  FIFO can accept a word this cycle.
REQ-011 tx  out  1  registered serial line, idle high.
REQ-012 busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-013 level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A word SHALL be accepted on the rising edge where in_valid && in_ready; in_ready = (level != FIFO_DEPTH), independent of in_valid.
REQ-015 Accepted words SHALL be transmitted in acceptance order, with no loss or duplication.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE = 0.
REQ-017 In IDLE with FIFO non-empty, the next edge SHALL pop the head into a shift register, enter START and drive tx = 0.
REQ-018 With an empty FIFO and IDLE engine, a word accepted at edge N SHALL produce tx = 0 after edge N+1.
REQ-019 Every bit SHALL last exactly CLKS_PER_BIT cycles; DATA sends DATA_BITS bits LSB first from the latched copy; later in_data changes SHALL NOT affect the frame.
REQ-020 Parity bit: XOR of the data bits (even), or its inverse (odd).
REQ-021 STOP SHALL drive tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-022 Frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) cycles; with defaults this is 176.
REQ-023 On the last STOP cycle with FIFO non-empty, the next edge SHALL pop and enter START, with zero idle cycles between frames; otherwise the FSM SHALL enter IDLE.
REQ-024 Push and pop on the same edge SHALL leave level unchanged.
REQ-025 No push SHALL occur when full; pop SHALL occur only when non-empty; pointers wrap modulo FIFO_DEPTH.
REQ-026 busy SHALL be (state != IDLE) || (level != 0), registered or derived from registers only.

Reset
REQ-027 rst_n low SHALL asynchronously force tx = 1, state = IDLE, level = 0, in_ready = 0, busy = 0, all counters and pointers = 0.
REQ-028 in_ready SHALL rise on the first edge after rst_n deasserts.
REQ-029 Reset mid-frame SHALL abort the frame; tx returns high immediately, and queued words are discarded.

Structure
REQ-030 Package uart_pkg SHALL hold the parity-mode constants, the FSM state enum and a frame-length function used by the RTL and the bench.
REQ-031 The FIFO SHALL be a separate sub-module uart_tx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); the framer FSM, bit counter and baud counter stay in uart_tx_framer.

Verification
REQ-032 Defaults, send 0x55 -> tx after the start edge: 0,1,0,1,0,1,0,1,0, parity 0, stop 1, each held 16 cycles; total 176 cycles; busy falls after the frame.
REQ-033 PARITY_MODE = 1 then 2, send 0x01 -> parity bit 1 (even), then 0 (odd).
REQ-034 DATA_BITS = 5, STOP_BITS = 2, CLKS_PER_BIT = 4, PARITY_MODE = 0, send 0x1F -> frame of 32 cycles: 4 low, 20 high data, 8 high stop.
REQ-035 Offer 6 words back-to-back, FIFO_DEPTH = 4, in_valid held high -> words 1..5 accepted (1 popped immediately), in_ready low for the 6th until the first frame ends; serial output shows 6 frames with no gaps, each start bit exactly 176 cycles after the previous one.
REQ-036 Assert rst_n low 50 cycles into a frame with 2 words queued -> tx = 1 within the same cycle, level = 0; after release, no residual frame is sent.
REQ-037 Change in_data every cycle during a frame -> transmitted bits match the word captured at acceptance.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit framer: parity-mode codes,
//   the framer FSM state type and helpers that compute frame geometry.
//   Used by the RTL and by the testbench so both agree on frame length.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Serial bits in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Clock cycles one frame occupies on the line.
  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity_mode, input int stop_bits);
    return clks_per_bit * frame_bits(data_bits, parity_mode, stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Small synchronous FIFO buffering words in front of the serial framer.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, push_data   write request and word (ignored when full)
//     pop               read request (ignored when empty); head advances
//     head              word at the front of the queue
//     full, empty       occupancy flags, derived from the count register
//     level             current occupancy, 0..DEPTH
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Buffered UART transmitter: words enter a FIFO and are serialised as
//   start / data (LSB first) / optional parity / stop bits on a registered
//   line that idles high. Frames are sent back-to-back while words remain.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_data      word to transmit
//     in_valid     in_data is offered; taken when in_ready is also high
//     in_ready     FIFO can take a word this cycle
//     tx           serial line
//     busy         a frame is on the line or words are waiting
//     level        FIFO occupancy
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = PARITY_EVEN,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam int BIT_W      = 4;
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  // bit_cnt indexes the whole frame: 0 is the start bit, so the last data
  // bit sits at index DATA_BITS and the last stop bit at FRAME_BITS-1.
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic              PARITY_INV = (PARITY_MODE == PARITY_ODD);

  tx_state_e             state;
  tx_state_e             state_next;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BAUD_W-1:0]     baud_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_next;
  logic [DATA_BITS-1:0]  shreg;
  logic [DATA_BITS-1:0]  shreg_next;
  logic                  par_q;
  logic                  par_next;
  logic                  tx_q;
  logic                  tx_next;
  logic                  ready_en;
  logic                  bit_done;
  logic                  load;
  logic                  pop;
  logic                  push;
  logic [DATA_BITS-1:0]  fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // ready_en holds in_ready low during reset and for the release cycle.
  assign in_ready = ready_en && !fifo_full;
  assign push     = in_valid && in_ready;
  assign tx       = tx_q;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign bit_done = (baud_cnt == BAUD_LAST);

  // State and datapath registers; tx is registered so the line is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      par_q    <= par_next;
      tx_q     <= tx_next;
      ready_en <= 1'b1;
    end
  end

  // Next-state logic. tx_next is the line value for the bit that begins
  // at the coming edge. A frame loads from the FIFO either from IDLE or on
  // the final stop cycle, which gives gapless back-to-back frames.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    par_next   = par_q;
    tx_next    = tx_q;
    load       = 1'b0;
    pop        = 1'b0;

    if (state != IDLE) begin
      baud_next = bit_done ? '0 : baud_cnt + 1'b1;
      if (bit_done) begin
        bit_next = bit_cnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          tx_next    = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == DATA_LAST) begin
            if (PARITY_MODE != PARITY_NONE) begin
              state_next = PARITY;
              tx_next    = par_q;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            shreg_next = shreg >> 1;
            tx_next    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done && (bit_cnt == FRAME_LAST)) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Latch the head word and its parity so later input changes cannot
    // disturb the frame.
    if (load) begin
      pop        = 1'b1;
      state_next = START;
      shreg_next = fifo_head;
      par_next   = (^fifo_head) ^ PARITY_INV;
      tx_next    = 1'b0;
      baud_next  = '0;
      bit_next   = '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Randomised and directed stimulus for uart_tx_framer. dut0 (defaults) is
//   compared every cycle against a queue-based waveform model; dut1 (odd
//   parity) and dut2 (5 data bits, 2 stops, 4 clocks/bit, no parity) get
//   directed frames with hand-computed expectations.
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int D_BITS = 8;
  localparam int CPB    = 16;
  localparam int PMODE  = PARITY_EVEN;
  localparam int SBITS  = 1;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  typedef bit wave_t[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;

  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, tx, busy;
  logic [LVL_W-1:0] level;

  logic [7:0]       in_data1 = '0;
  logic             in_valid1 = 1'b0;
  logic             in_ready1, tx1, busy1;
  logic [LVL_W-1:0] level1;

  logic [4:0]       in_data2 = '0;
  logic             in_valid2 = 1'b0;
  logic             in_ready2, tx2, busy2;
  logic [LVL_W-1:0] level2;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_framer #(
    .DATA_BITS(D_BITS), .CLKS_PER_BIT(CPB), .PARITY_MODE(PMODE),
    .STOP_BITS(SBITS), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .level(level)
  );

  uart_tx_framer #(
    .DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_MODE(PARITY_ODD),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .level(level1)
  );

  uart_tx_framer #(
    .DATA_BITS(5), .CLKS_PER_BIT(4), .PARITY_MODE(PARITY_NONE),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .level(level2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t: timed out waiting", name, $time);
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  // Expected line waveform of one default-configuration frame, cycle by cycle.
  function automatic wave_t frameWave(input logic [7:0] w);
    wave_t q;
    bit    bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < D_BITS; i++) bits.push_back(w[i]);
    if (PMODE != PARITY_NONE) bits.push_back((^w) ^ (PMODE == PARITY_ODD));
    for (int i = 0; i < SBITS; i++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c < CPB; c++) q.push_back(bits[b]);
    end
    return q;
  endfunction

  // Model of dut0: a queue of waiting words and the remaining waveform of
  // the frame on the line. A new frame starts at any edge where the line
  // waveform has run out and a word was already waiting before that edge.
  logic [7:0] mq[$];
  wave_t      line;
  bit         m_tx = 1'b1;
  bit         m_active = 1'b0;
  bit         m_ready = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit push;
    if (!rst_n) begin
      mq.delete();
      line.delete();
      m_tx     = 1'b1;
      m_active = 1'b0;
      m_ready  = 1'b0;
    end else begin
      push = in_valid && m_ready && (mq.size() != DEPTH);
      if (line.size() == 0 && mq.size() != 0) line = frameWave(mq.pop_front());
      if (line.size() != 0) begin
        m_tx     = line.pop_front();
        m_active = 1'b1;
      end else begin
        m_tx     = 1'b1;
        m_active = 1'b0;
      end
      if (push) mq.push_back(in_data);
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("tx", 32'(tx), 32'(m_tx));
      checkOutput("in_ready", 32'(in_ready), 32'(m_ready && (mq.size() != DEPTH)));
      checkOutput("busy", 32'(busy), 32'(m_active || (mq.size() != 0)));
      checkOutput("level", 32'(level), 32'(mq.size()));
    end
  end

  task automatic waitIdle(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) timeoutFail(tag);
  endtask

  task automatic waitTxLow(input string tag, input int max);
    int n = 0;
    while (tx !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) timeoutFail(tag);
  endtask

  // Starting at the negedge inside cycle 0 of a frame, sample every bit at
  // mid-bit (e0/e1 bit b = expected line value of frame bit b) and measure
  // cycles until busy drops.
  task automatic frameWatch(input string tag, input logic [10:0] e0,
                            input logic [10:0] e1, input bit use1);
    int cyc = 0;
    while (cyc < 400) begin
      if ((cyc % CPB) == (CPB / 2) && (cyc / CPB) < 11) begin
        checkOutput($sformatf("%s_bit%0d", tag, cyc / CPB), 32'(tx), 32'(e0[cyc / CPB]));
        if (use1)
          checkOutput($sformatf("%s_dut1_bit%0d", tag, cyc / CPB), 32'(tx1), 32'(e1[cyc / CPB]));
      end
      if (busy === 1'b0) break;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_len"}, 32'(cyc), 32'd176);
    if (use1) checkOutput({tag, "_dut1_busy"}, 32'(busy1), 32'd0);
  endtask

  logic [7:0] w6 [6] = '{8'h11, 8'h22, 8'h83, 8'h44, 8'hC5, 8'h96};

  initial begin
    wave_t wave;
    int    k, guard, wait6, cyc;
    bit    pend, first6;

    // Pin the model against hand-computed frame contents.
    wave = frameWave(8'h55);
    checkOutput("model_len", 32'(wave.size()), 32'd176);
    checkOutput("model_start", 32'(wave[8]), 32'd0);
    checkOutput("model_d0", 32'(wave[24]), 32'd1);
    checkOutput("model_par55", 32'(wave[152]), 32'd0);
    checkOutput("model_stop", 32'(wave[175]), 32'd1);
    wave = frameWave(8'h01);
    checkOutput("model_par01", 32'(wave[152]), 32'd1);

    // Reset and release.
    #1 rst_n = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("ready_at_release", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_first_edge", 32'(in_ready), 32'd1);
    checkOutput("dut2_ready", 32'(in_ready2), 32'd1);

    // 0x55 on defaults: 0,1,0,1,0,1,0,1,0, parity 0, stop 1.
    $display("[TB] single frame 0x55");
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b0, 8'h00);
    waitTxLow("start55", 20);
    frameWatch("f55", 11'h4AA, 11'h000, 1'b0);

    // 0x01: even parity 1 on dut0, odd parity 0 on dut1.
    $display("[TB] parity frames 0x01");
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h01; in_valid1 = 1'b1; in_data1 = 8'h01;
    @(negedge clk);
    in_valid = 1'b0; in_valid1 = 1'b0;
    waitTxLow("start01", 20);
    checkOutput("start01_dut1", 32'(tx1), 32'd0);
    frameWatch("p01", 11'h602, 11'h402, 1'b1);

    // dut2: 0x1F -> 4 low, 28 high, 32 cycles; in_data2 churns mid-frame.
    $display("[TB] short frame on dut2");
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = 5'h1F;
    @(negedge clk);
    in_valid2 = 1'b0;
    guard = 0;
    while (tx2 !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (tx2 !== 1'b0) timeoutFail("start_d5");
    cyc = 0;
    while (cyc < 100) begin
      if (cyc < 32) checkOutput($sformatf("d5_c%0d", cyc), 32'(tx2), (cyc < 4) ? 32'd0 : 32'd1);
      if (busy2 === 1'b0) break;
      @(negedge clk);
      in_data2 = 5'($urandom);
      cyc++;
    end
    checkOutput("d5_len", 32'(cyc), 32'd32);

    // Random traffic with in_data changing every cycle.
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 99) < ((i < 700) ? 40 : 3), 8'($urandom));
    applyStimulus(1'b0, 8'h00);
    waitIdle("rand_drain", 3000);

    // Six words back-to-back with in_valid held high.
    $display("[TB] back-to-back six words");
    k = 0; pend = 1'b0; guard = 0; wait6 = 0; first6 = 1'b1;
    while (k < 6 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (pend) k++;
      pend = 1'b0;
      if (k < 6) begin
        in_valid = 1'b1;
        in_data  = w6[k];
        pend     = in_ready;
        if (k == 5) begin
          if (first6) begin
            checkOutput("b2b_full_level", 32'(level), 32'd4);
            checkOutput("b2b_full_ready", 32'(in_ready), 32'd0);
            first6 = 1'b0;
          end else begin
            wait6++;
          end
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    if (k < 6) timeoutFail("b2b_accept");
    checkOutput("b2b_wait6", 32'(wait6), 32'd173);
    waitIdle("b2b_drain", 2000);

    // Reset 50 cycles into a frame with two words queued.
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b0, 8'h00);
    repeat (49) @(negedge clk);
    checkOutput("mid_tx_low", 32'(tx), 32'd0);
    checkOutput("mid_level", 32'(level), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_tx", 32'(tx), 32'd1);
    checkOutput("abort_level", 32'(level), 32'd0);
    checkOutput("abort_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_tx", 32'(tx), 32'd1);
    checkOutput("dut1_idle_busy", 32'(busy1), 32'd0);
    checkOutput("dut1_idle_level", 32'(level1), 32'd0);
    checkOutput("dut1_idle_ready", 32'(in_ready1), 32'd1);
    checkOutput("dut2_idle_level", 32'(level2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog at %0t: simulation did not complete", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
